// File: rtl/max_finder.sv
// Argmax classifier: captures a layer's parallel outputs on a strobe, then scans
// them one per cycle and reports the index/value of the largest signed output.
module max_finder #(
   parameter int NEURON_NUM = 10,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_in,
   input  logic [NEURON_NUM-1:0]            layer_in_valid,
   output logic [IDX_WIDTH-1:0]             max_idx,
   output logic [DATA_WIDTH-1:0]            max_val,
   output logic                             out_valid,
   output logic                             busy,
   output logic                             overrun
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] buf_q [NEURON_NUM];
   logic [DATA_WIDTH-1:0] buf_d [NEURON_NUM];
   logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
   logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
   logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
   logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;

   logic [DATA_WIDTH-1:0] cand;
   logic                  cand_gt;
   logic                  last;

   // Only bit 0 strobes capture; the other neurons are timing-identical.
   logic unused_valid_bits;
   assign unused_valid_bits = ^layer_in_valid[NEURON_NUM-1:1];

   assign cand    = buf_q[cnt_q];
   assign cand_gt = $signed(cand) > $signed(run_max_q);
   assign last    = (cnt_q == IDX_WIDTH'(NEURON_NUM - 1));

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d     = state_q;
      buf_d       = buf_q;
      run_max_d   = run_max_q;
      run_idx_d   = run_idx_q;
      cnt_d       = cnt_q;
      max_idx_d   = max_idx_q;
      max_val_d   = max_val_q;
      busy_d      = busy_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (layer_in_valid[0]) begin
               for (int i = 0; i < NEURON_NUM; i++) begin
                  buf_d[i] = layer_in[i*DATA_WIDTH +: DATA_WIDTH];
               end
               run_max_d = layer_in[DATA_WIDTH-1:0];
               run_idx_d = '0;
               cnt_d     = IDX_WIDTH'(1);
               busy_d    = 1'b1;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            overrun_d = layer_in_valid[0];
            // Strictly greater keeps the lowest index on ties.
            if (cand_gt) begin
               run_max_d = cand;
               run_idx_d = cnt_q;
            end
            if (last) begin
               max_val_d   = cand_gt ? cand  : run_max_q;
               max_idx_d   = cand_gt ? cnt_q : run_idx_q;
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + IDX_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         // NOTE: the capture buffer is reset explicitly so a reset leaves no stale frame.
         for (int i = 0; i < NEURON_NUM; i++) begin
            buf_q[i] <= '0;
         end
         run_max_q   <= '0;
         run_idx_q   <= '0;
         cnt_q       <= '0;
         max_idx_q   <= '0;
         max_val_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         state_q     <= state_d;
         buf_q       <= buf_d;
         run_max_q   <= run_max_d;
         run_idx_q   <= run_idx_d;
         cnt_q       <= cnt_d;
         max_idx_q   <= max_idx_d;
         max_val_q   <= max_val_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign max_idx   = max_idx_q;
   assign max_val   = max_val_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder: directed frames plus random frames checked
// against an argmax reference model, including overrun, back-to-back and reset.
module tb_max_finder;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   typedef logic [W-1:0] frame_t [N];

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  layer_in;
   logic [N-1:0]    layer_in_valid;
   logic [IW-1:0]   max_idx;
   logic [W-1:0]    max_val;
   logic            out_valid;
   logic            busy;
   logic            overrun;

   int n_checks = 0;
   int n_fail   = 0;

   max_finder #(.NEURON_NUM(N), .DATA_WIDTH(W), .IDX_WIDTH(IW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .layer_in       (layer_in),
      .layer_in_valid (layer_in_valid),
      .max_idx        (max_idx),
      .max_val        (max_val),
      .out_valid      (out_valid),
      .busy           (busy),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: largest signed value, then the first position holding it.
   function automatic void ref_max(input frame_t f, output int idx, output logic [W-1:0] val);
      int best;
      best = int'($signed(f[0]));
      for (int i = 1; i < N; i++)
         if (int'($signed(f[i])) > best) best = int'($signed(f[i]));
      idx = -1;
      for (int i = N - 1; i >= 0; i--)
         if (int'($signed(f[i])) == best) idx = i;
      val = W'(best);
   endfunction

   task automatic drive_frame(input frame_t f);
      for (int i = 0; i < N; i++) layer_in[i*W +: W] = f[i];
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) layer_in[i*W +: W] = W'($urandom);
   endtask

   // Strobe f in the current cycle (cycle 0) and check cycles 1..N.
   // drop_cycle >= 1 raises a second strobe mid-scan; scramble perturbs layer_in.
   // Returns in cycle N with out_valid expected high.
   task automatic run_frame(input frame_t f, input string tag, input bit scramble,
                            input int drop_cycle);
      int            e_idx;
      logic [W-1:0]  e_val;
      ref_max(f, e_idx, e_val);
      drive_frame(f);
      layer_in_valid = '1;
      tick();
      layer_in_valid = '0;
      for (int c = 1; c < N; c++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
         check({tag, "_overrun"}, 32'(overrun), 32'(c == drop_cycle + 1));
         layer_in_valid = (c == drop_cycle) ? '1 : '0;
         if (scramble || c == drop_cycle) drive_random();
         tick();
      end
      layer_in_valid = '0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_idx"}, 32'(max_idx), 32'(e_idx));
      check({tag, "_val"}, 32'(max_val), 32'(e_val));
   endtask

   task automatic check_hold(input string tag, input logic [IW-1:0] idx, input logic [W-1:0] val);
      tick();
      check({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
      check({tag, "_hold_idx"}, 32'(max_idx), 32'(idx));
      check({tag, "_hold_val"}, 32'(max_val), 32'(val));
   endtask

   initial begin
      frame_t f;
      frame_t g;
      int     e_idx;
      logic [W-1:0] e_val;

      rst_n          = 1'b0;
      layer_in       = '0;
      layer_in_valid = '0;
      repeat (3) tick();
      check("rst_idx", 32'(max_idx), 32'd0);
      check("rst_val", 32'(max_val), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single frame, peak 900 at element 5.
      for (int i = 0; i < N; i++) f[i] = W'(i);
      f[5] = 16'd900;
      run_frame(f, "single", 1'b0, -1);
      check("single_idx_abs", 32'(max_idx), 32'd5);
      check_hold("single", 4'd5, 16'd900);

      // Tie between elements 2 and 7.
      for (int i = 0; i < N; i++) f[i] = 16'h0100;
      f[2] = 16'h0400;
      f[7] = 16'h0400;
      tick();
      run_frame(f, "tie", 1'b0, -1);
      check("tie_idx_abs", 32'(max_idx), 32'd2);

      // All negative, -2 at element 8.
      for (int i = 0; i < N; i++) f[i] = 16'hFF00;
      f[8] = 16'hFFFE;
      tick();
      run_frame(f, "neg", 1'b0, -1);
      check("neg_val_abs", 32'(max_val), 32'h0000_FFFE);

      // Max at index 0 (most positive value) and at index N-1.
      for (int i = 0; i < N; i++) f[i] = W'($urandom_range(0, 16'h7000));
      f[0] = 16'h7FFF;
      tick();
      run_frame(f, "first", 1'b0, -1);
      for (int i = 0; i < N; i++) f[i] = 16'h8000 + W'(i);
      f[N-1] = 16'h0001;
      tick();
      run_frame(f, "last", 1'b0, -1);
      check("last_idx_abs", 32'(max_idx), 32'(N - 1));

      // Overrun mid-scan with scrambled inputs, then a back-to-back frame.
      for (int i = 0; i < N; i++) f[i] = W'(100 + i);
      f[3] = 16'd2000;
      for (int i = 0; i < N; i++) g[i] = W'(50 + i);
      g[6] = 16'd3000;
      tick();
      run_frame(f, "ovr", 1'b1, 4);
      run_frame(g, "b2b", 1'b0, -1);
      check("b2b_idx_abs", 32'(max_idx), 32'd6);
      check_hold("b2b", 4'd6, 16'd3000);

      // Reset in cycle 5 of a scan.
      for (int i = 0; i < N; i++) f[i] = W'($urandom);
      drive_frame(f);
      layer_in_valid = '1;
      tick();
      layer_in_valid = '0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      check("mrst_idx", 32'(max_idx), 32'd0);
      check("mrst_val", 32'(max_val), 32'd0);
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < N; c++) begin
         tick();
         check("mrst_no_valid", 32'(out_valid), 32'd0);
         check("mrst_idle", 32'(busy), 32'd0);
      end
      for (int i = 0; i < N; i++) f[i] = W'($urandom);
      run_frame(f, "post_rst", 1'b0, -1);

      // Random frames: full-range, and narrow-range to force ties.
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < N; i++)
            f[i] = (k % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 3)) - W'(2);
         if ($urandom_range(0, 1) == 1) tick();
         run_frame(f, "rand", 1'(k % 3 == 0), (k % 5 == 0) ? int'($urandom_range(1, N - 2)) : -1);
      end
      ref_max(f, e_idx, e_val);
      check_hold("rand", IW'(e_idx), e_val);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected end before 1000000");
      $fatal(1);
   end

endmodule
